// File: rtl/sm_context_swapper.sv
// Context-swap engine behind the SM scheduler: saves the live context of the current SM, then restores the next one.
// Optional build macro CTX_DIRTY_SKIP_EN skips the save phase when the live context is clean.
module sm_context_swapper #(
    parameter int SM_LOG       = 2,
    parameter int CTX_WORDS    = 8,
    parameter int CTX_WORD_LOG = 3,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic [SM_LOG-1:0]       sm_i,
    input  logic [SM_LOG-1:0]       nSM_i,
    input  logic                    swap_req_i,
    input  logic                    ctx_dirty_i,
    output logic [CTX_WORD_LOG-1:0] ctx_rd_addr_o,
    input  logic [DATA_W-1:0]       ctx_rd_data_i,
    output logic                    ctx_wr_en_o,
    output logic [CTX_WORD_LOG-1:0] ctx_wr_addr_o,
    output logic [DATA_W-1:0]       ctx_wr_data_o,
    output logic                    busy_o,
    output logic                    swap_done_o,
    output logic [15:0]             swap_cnt_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SAVE    = 2'd1;
    localparam logic [1:0] RESTORE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int                      SM_NUM  = 2 ** SM_LOG;
    localparam logic [CTX_WORD_LOG-1:0] WC_LAST = CTX_WORD_LOG'(CTX_WORDS - 1);
    localparam logic [CTX_WORD_LOG-1:0] WC_ONE  = CTX_WORD_LOG'(1);
    localparam logic [SM_LOG-1:0]       SM_ONE  = SM_LOG'(1);

    logic [1:0]              state;
    logic [CTX_WORD_LOG-1:0] wc;
    logic [SM_LOG-1:0]       cur;
    logic [SM_LOG-1:0]       nxt;
    logic [SM_LOG-1:0]       nxt_calc;
    logic [15:0]             swap_cnt;
    logic                    skip_save;
    logic [DATA_W-1:0]       ctx_tbl [SM_NUM][CTX_WORDS];

    // Round-robin successor, wrapping at the scheduler's highest allowed SM.
    assign nxt_calc = (sm_i == nSM_i) ? '0 : sm_i + SM_ONE;

`ifdef CTX_DIRTY_SKIP_EN
    assign skip_save = !ctx_dirty_i;
`else
    logic unused_dirty;
    assign unused_dirty = ctx_dirty_i;
    assign skip_save    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wc       <= '0;
            cur      <= '0;
            nxt      <= '0;
            swap_cnt <= '0;
            for (int s = 0; s < SM_NUM; s++) begin
                for (int w = 0; w < CTX_WORDS; w++) begin
                    ctx_tbl[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (swap_req_i && !stall_i) begin
                        cur <= sm_i;
                        nxt <= nxt_calc;
                        wc  <= '0;
                        if (nxt_calc == sm_i) begin
                            state <= DONE;
                        end else if (skip_save) begin
                            state <= RESTORE;
                        end else begin
                            state <= SAVE;
                        end
                    end
                end
                SAVE: begin
                    if (!stall_i) begin
                        ctx_tbl[cur][wc] <= ctx_rd_data_i;
                        if (wc == WC_LAST) begin
                            wc    <= '0;
                            state <= RESTORE;
                        end else begin
                            wc <= wc + WC_ONE;
                        end
                    end
                end
                RESTORE: begin
                    if (!stall_i) begin
                        if (wc == WC_LAST) begin
                            wc    <= '0;
                            state <= DONE;
                        end else begin
                            wc <= wc + WC_ONE;
                        end
                    end
                end
                DONE: begin
                    // Completion is never held off by a stall so the scheduler always sees it.
                    swap_cnt <= swap_cnt + 16'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o        = (state != IDLE);
    assign swap_done_o   = (state == DONE);
    assign swap_cnt_o    = swap_cnt;
    assign ctx_rd_addr_o = (state == SAVE) ? wc : '0;
    assign ctx_wr_en_o   = (state == RESTORE) && !stall_i;
    assign ctx_wr_addr_o = (state == RESTORE) ? wc : '0;
    assign ctx_wr_data_o = (state == RESTORE) ? ctx_tbl[nxt][wc] : '0;

endmodule

// File: doc/sm_context_swapper.md
Name: sm_context_swapper

Overview:
- Context-swap engine sitting directly downstream of the SM scheduler.
- On a swap request at a granule boundary it does two things, then pulses swap_done_o, which feeds the scheduler's swap-done input:
  - saves the live pipeline context of the current SM into an internal per-SM context table;
  - restores the context of the next SM into the pipeline.
- Stalls are respected; an accepted swap never aborts.

Parameters:
- SM_LOG, 2, width of SM index; the context table holds 2**SM_LOG entries.
- CTX_WORDS, 8, context words per SM (PC, active mask, reconvergence stack, ...).
- CTX_WORD_LOG, 3, width of word index; CTX_WORDS <= 2**CTX_WORD_LOG.
- DATA_W, 32, context word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  global pipeline stall; freezes FSM, counter and all writes.
- sm_i  in  SM_LOG  SM currently running (scheduler sm output).
- nSM_i  in  SM_LOG  highest allowed SM index (same value the scheduler uses).
- swap_req_i  in  1  level request; sampled only in IDLE.
- ctx_dirty_i  in  1  live context modified since last restore; used only with the optional feature.
- ctx_rd_addr_o  out  CTX_WORD_LOG  live-context read word index.
- ctx_rd_data_i  in  DATA_W  live-context read data; combinational from ctx_rd_addr_o.
- ctx_wr_en_o  out  1  live-context write strobe.
- ctx_wr_addr_o  out  CTX_WORD_LOG  live-context write word index.
- ctx_wr_data_o  out  DATA_W  live-context write data.
- busy_o  out  1  high in any state other than IDLE.
- swap_done_o  out  1  one-cycle completion pulse.
- swap_cnt_o  out  16  completed-swap counter; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values:
  - all outputs 0; FSM in IDLE;
  - word counter wc=0;
  - latched SMs cur=0, nxt=0;
  - context table zeroed.
- Next-SM rule: nxt = (sm_i == nSM_i) ? 0 : sm_i+1, computed and latched with cur=sm_i when leaving IDLE.
- FSM states: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - if swap_req_i && !stall_i, latch cur/nxt and clear wc;
  - go to DONE if nxt==cur (single-SM case), else go to SAVE.
- SAVE:
  - per unstalled cycle: ctx_rd_addr_o=wc, table[cur][wc] <= ctx_rd_data_i, wc++;
  - after the word with wc==CTX_WORDS-1: wc<=0, go to RESTORE.
- RESTORE:
  - per unstalled cycle: ctx_wr_en_o=1, ctx_wr_addr_o=wc, ctx_wr_data_o=table[nxt][wc], wc++;
  - after the last word: go to DONE.
  - ctx_wr_en_o is combinational from state, forced 0 while stall_i.
- DONE:
  - swap_done_o=1 for exactly one cycle and swap_cnt_o increments;
  - go to IDLE unconditionally, even if stall_i=1.
- Outputs in IDLE/SAVE/DONE: ctx_wr_en_o=0; ctx_wr_addr_o and ctx_wr_data_o driven 0.
- Latency: swap_done_o is high 2*CTX_WORDS+1 cycles after the accepting edge (17 for defaults). For nxt==cur it is high 1 cycle after acceptance.
- Stall: each stalled cycle in SAVE/RESTORE adds one cycle of latency. No table write, no wc change, no state change.
- swap_req_i falling mid-swap is ignored; the swap completes.
- swap_req_i still high in the cycle after DONE is accepted as a new request (the scheduler drops it once sm advances).
- sm_i/nSM_i changes while busy are ignored; the latched values are used.
- Reset mid-swap: immediate return to IDLE, outputs 0, table zeroed. A partially written live context is not repaired.
- Only one swap is in flight at a time; there is no queueing.

Optional Feature:
- Macro: CTX_DIRTY_SKIP_EN.
- Defined: ctx_dirty_i is sampled on acceptance. If it is 0 and nxt!=cur, IDLE goes straight to RESTORE (SAVE skipped) and latency becomes CTX_WORDS+1.
- Undefined: ctx_dirty_i is ignored and SAVE always runs.

Test Plan:
- Reset, then swap_req_i=1, sm_i=0, nSM_i=3, live words 0x100+i:
  - table[0][i]=0x100+i;
  - writes addr 0..7 of data 0 (table[1] still zero);
  - swap_done_o at cycle 17; swap_cnt_o=1.
- Wrap: sm_i=3, nSM_i=3 -> nxt=0. After a prior save of SM0, RESTORE drives 0x100..0x107 to addr 0..7.
- nSM_i=0, sm_i=0, request -> DONE next cycle; swap_done_o at cycle 1; no ctx_wr_en_o pulses.
- stall_i high for 3 cycles during SAVE word 4 and 2 cycles during RESTORE word 6 -> done at cycle 22; table contents and write sequence unchanged.
- Reset asserted in RESTORE word 3 -> next cycle busy_o=0, swap_done_o never pulses, swap_cnt_o=0.
- With CTX_DIRTY_SKIP_EN, ctx_dirty_i=0 -> no table write; done at cycle 9. Without the macro, same stimulus -> done at cycle 17.
